instruction_fetch_mem: RTL and testbench

INSTRUCTION_FETCH_MEM -- requirements
Module: instruction_fetch_mem

---
 rtl/instruction_fetch_mem.sv | 139 +++++++++++++
 tb/tb_instruction_fetch_mem.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_mem.sv
// Instruction memory with a power-up clear sequence, a program-load write port,
// and a stallable one-cycle-latency fetch port with range checking.
module instruction_fetch_mem #(
    parameter int unsigned DW          = 32,
    parameter int unsigned AW          = 32,
    parameter int unsigned DEPTH       = 32,
    parameter int unsigned WRITE_FIRST = 1
) (
    input  logic          clka,
    input  logic          rsta,
    input  logic          wea,
    input  logic [AW-1:0] addra,
    input  logic [DW-1:0] dina,
    output logic          load_err,
    input  logic          fetch_req,
    input  logic [AW-1:0] fetch_addr,
    input  logic          fetch_stall,
    output logic          fetch_ready,
    output logic [DW-1:0] douta,
    output logic          douta_valid,
    output logic          addr_err,
    output logic          init_done
);

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] clr_cnt_q, clr_cnt_d;
    logic [DW-1:0] douta_q, douta_d;
    logic          douta_valid_q, douta_valid_d;
    logic          addr_err_q, addr_err_d;
    logic          load_err_q, load_err_d;

    logic [DW-1:0] mem_q [DEPTH];

    logic          fetchInRange;
    logic          loadInRange;
    logic          accept;
    logic          collision;
    logic [DW-1:0] readData;
    logic          memWriteEn;
    logic [IW-1:0] memWriteIdx;
    logic [DW-1:0] memWriteData;

    assign fetchInRange = (fetch_addr < AW'(DEPTH));
    assign loadInRange  = (addra < AW'(DEPTH));

    // Reset gates readiness so an edge with rsta high never counts as an acceptance.
    assign fetch_ready  = (state_q == RUN) && !fetch_stall && !rsta;
    assign accept       = fetch_req && fetch_ready;
    assign collision    = wea && loadInRange && (addra == fetch_addr);

    // mem_q still holds the pre-write word at the edge, so read-first falls out naturally.
    assign readData = ((WRITE_FIRST != 0) && collision) ? dina : mem_q[fetch_addr[IW-1:0]];

    always_comb begin
        memWriteEn   = 1'b0;
        memWriteIdx  = '0;
        memWriteData = '0;
        if (!rsta) begin
            if (state_q == CLEAR) begin
                memWriteEn  = 1'b1;
                memWriteIdx = clr_cnt_q;
            end else if (wea && loadInRange) begin
                memWriteEn   = 1'b1;
                memWriteIdx  = addra[IW-1:0];
                memWriteData = dina;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        clr_cnt_d     = clr_cnt_q;
        douta_d       = douta_q;
        douta_valid_d = douta_valid_q;
        addr_err_d    = addr_err_q;
        load_err_d    = 1'b0;

        case (state_q)
            CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == IW'(DEPTH - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                load_err_d = wea && !loadInRange;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase

        if (accept) begin
            douta_d       = fetchInRange ? readData : '0;
            addr_err_d    = !fetchInRange;
            douta_valid_d = 1'b1;
        end else if (!fetch_stall) begin
            douta_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clka) begin
        if (rsta) begin
            state_q       <= CLEAR;
            clr_cnt_q     <= '0;
            douta_q       <= '0;
            douta_valid_q <= 1'b0;
            addr_err_q    <= 1'b0;
            load_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            clr_cnt_q     <= clr_cnt_d;
            douta_q       <= douta_d;
            douta_valid_q <= douta_valid_d;
            addr_err_q    <= addr_err_d;
            load_err_q    <= load_err_d;
        end
    end

    always_ff @(posedge clka) begin
        if (memWriteEn) begin
            mem_q[memWriteIdx] <= memWriteData;
        end
    end

    assign douta       = douta_q;
    assign douta_valid = douta_valid_q;
    assign addr_err    = addr_err_q;
    assign load_err    = load_err_q;
    assign init_done   = (state_q == RUN);

endmodule

// File: tb/tb_instruction_fetch_mem.sv
// Scoreboard bench: the driver queues the expected word for every fetch it issues,
// and a monitor pops and compares one cycle after each accepted fetch.
module tb_instruction_fetch_mem;

    logic        clka;
    logic        rsta;
    logic        wea;
    logic [31:0] addra;
    logic [31:0] dina;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_stall;

    logic        load_err, fetch_ready, douta_valid, addr_err, init_done;
    logic [31:0] douta;
    logic        load_err0, fetch_ready0, douta_valid0, addr_err0, init_done0;
    logic [31:0] douta0;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } expect_t;

    expect_t expQ[$];
    int      total;
    int      bad;

    instruction_fetch_mem #(.DW(32), .AW(32), .DEPTH(32), .WRITE_FIRST(1)) dut (
        .clka(clka), .rsta(rsta), .wea(wea), .addra(addra), .dina(dina),
        .load_err(load_err), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_stall(fetch_stall), .fetch_ready(fetch_ready), .douta(douta),
        .douta_valid(douta_valid), .addr_err(addr_err), .init_done(init_done)
    );

    // Read-first instance sharing all inputs; only its collision result is inspected.
    instruction_fetch_mem #(.DW(32), .AW(32), .DEPTH(32), .WRITE_FIRST(0)) dut0 (
        .clka(clka), .rsta(rsta), .wea(wea), .addra(addra), .dina(dina),
        .load_err(load_err0), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_stall(fetch_stall), .fetch_ready(fetch_ready0), .douta(douta0),
        .douta_valid(douta_valid0), .addr_err(addr_err0), .init_done(init_done0)
    );

    initial begin
        clka = 1'b0;
        forever #5 clka = ~clka;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic req, input logic [31:0] faddr,
                                 input logic stall, input logic we,
                                 input logic [31:0] waddr, input logic [31:0] wdata);
        fetch_req   = req;
        fetch_addr  = faddr;
        fetch_stall = stall;
        wea         = we;
        addra       = waddr;
        dina        = wdata;
    endtask

    task automatic tick();
        @(negedge clka);
    endtask

    task automatic fetchWord(input logic [31:0] faddr, input logic [31:0] expData,
                             input logic expErr);
        expect_t e;
        e.data = expData;
        e.err  = expErr;
        expQ.push_back(e);
        applyStimulus(1'b1, faddr, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();
    endtask

    task automatic idle();
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    // Monitor: latch acceptance at the edge, compare the registered result half a cycle later.
    initial begin
        logic    acc;
        expect_t e;
        forever begin
            @(posedge clka);
            acc = fetch_req && fetch_ready && !rsta;
            @(negedge clka);
            if (acc) begin
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpectedFetch: got douta=0x%08h with no expected entry", douta);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("fetchValid", {31'd0, douta_valid}, 32'd1);
                    checkOutput("fetchData", douta, e.data);
                    checkOutput("fetchAddrErr", {31'd0, addr_err}, {31'd0, e.err});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no completion expected finish before 200000");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        total = 0;
        bad   = 0;
        rsta  = 1'b1;
        idle();
        repeat (3) tick();

        checkOutput("rstDouta", douta, 32'd0);
        checkOutput("rstValid", {31'd0, douta_valid}, 32'd0);
        checkOutput("rstAddrErr", {31'd0, addr_err}, 32'd0);
        checkOutput("rstLoadErr", {31'd0, load_err}, 32'd0);
        checkOutput("rstInitDone", {31'd0, init_done}, 32'd0);
        checkOutput("rstReady", {31'd0, fetch_ready}, 32'd0);

        // Clear phase: fetches and loads (in and out of range) must all be ignored.
        rsta = 1'b0;
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b1, 32'd5, 1'b0, 1'b1, (i % 2 == 0) ? 32'd0 : 32'd40, 32'hA5A5A5A5);
            #1;
            checkOutput("clearInitDone", {31'd0, init_done}, 32'd0);
            checkOutput("clearReady", {31'd0, fetch_ready}, 32'd0);
            checkOutput("clearLoadErr", {31'd0, load_err}, 32'd0);
            tick();
        end
        idle();
        #1;
        checkOutput("initDoneAt32", {31'd0, init_done}, 32'd1);
        checkOutput("readyAfterClear", {31'd0, fetch_ready}, 32'd1);

        for (int a = 0; a < 32; a++) begin
            fetchWord(32'(a), 32'd0, 1'b0);
        end

        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 32'd1, 32'h24430001);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 32'd2, 32'h20410001);
        tick();
        fetchWord(32'd1, 32'h24430001, 1'b0);
        fetchWord(32'd2, 32'h20410001, 1'b0);

        fetchWord(32'd40, 32'd0, 1'b1);
        idle();
        tick();
        checkOutput("idleValidLow", {31'd0, douta_valid}, 32'd0);
        checkOutput("idleAddrErrHold", {31'd0, addr_err}, 32'd1);

        // Out-of-range load must not alias onto address 0.
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 32'd32, 32'hDEADBEEF);
        tick();
        checkOutput("loadErrPulse", {31'd0, load_err}, 32'd1);
        idle();
        tick();
        checkOutput("loadErrOneCycle", {31'd0, load_err}, 32'd0);
        fetchWord(32'd0, 32'd0, 1'b0);

        fetchWord(32'd1, 32'h24430001, 1'b0);
        applyStimulus(1'b1, 32'd2, 1'b1, 1'b0, 32'd0, 32'd0);
        #1;
        checkOutput("stallReady", {31'd0, fetch_ready}, 32'd0);
        for (int s = 0; s < 3; s++) begin
            tick();
            checkOutput("stallDouta", douta, 32'h24430001);
            checkOutput("stallValid", {31'd0, douta_valid}, 32'd1);
            checkOutput("stallAddrErr", {31'd0, addr_err}, 32'd0);
            checkOutput("stallReadyHeld", {31'd0, fetch_ready}, 32'd0);
        end
        idle();
        tick();
        checkOutput("postStallValid", {31'd0, douta_valid}, 32'd0);
        checkOutput("postStallDouta", douta, 32'h24430001);

        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 32'd3, 32'h11111111);
        tick();
        begin
            expect_t e;
            e.data = 32'h00410001;
            e.err  = 1'b0;
            expQ.push_back(e);
            applyStimulus(1'b1, 32'd3, 1'b0, 1'b1, 32'd3, 32'h00410001);
            tick();
        end
        checkOutput("collisionReadFirst", douta0, 32'h11111111);
        fetchWord(32'd3, 32'h00410001, 1'b0);
        checkOutput("refetchReadFirst", douta0, 32'h00410001);

        fetchWord(32'd2, 32'h20410001, 1'b0);
        checkOutput("preResetValid", {31'd0, douta_valid}, 32'd1);
        rsta = 1'b1;
        applyStimulus(1'b1, 32'd1, 1'b0, 1'b1, 32'd40, 32'd0);
        tick();
        checkOutput("midRstDouta", douta, 32'd0);
        checkOutput("midRstValid", {31'd0, douta_valid}, 32'd0);
        checkOutput("midRstAddrErr", {31'd0, addr_err}, 32'd0);
        checkOutput("midRstLoadErr", {31'd0, load_err}, 32'd0);
        checkOutput("midRstInitDone", {31'd0, init_done}, 32'd0);
        checkOutput("midRstReady", {31'd0, fetch_ready}, 32'd0);
        rsta = 1'b0;
        idle();
        repeat (31) tick();
        checkOutput("reclearNotDone", {31'd0, init_done}, 32'd0);
        tick();
        checkOutput("reclearDone", {31'd0, init_done}, 32'd1);
        fetchWord(32'd1, 32'd0, 1'b0);
        idle();
        repeat (2) tick();

        checkOutput("scoreboardDrained", 32'(expQ.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
